// File: rtl/tx_enc6466_scr.sv
// tx_enc6466_scr: transmit-side 64b/66b scrambler (x^58 + x^39 + 1) with one valid/ready register stage.
// Optional: define TX6466_SCR_BYPASS_EN to add the scr_bypass input (payload passed through unscrambled).
module tx_enc6466_scr #(
  parameter logic [57:0] SEED      = 58'h0,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          in_data,
  input  logic [1:0]           in_header,
  input  logic                 in_valid,
  output logic                 in_ready,
`ifdef TX6466_SCR_BYPASS_EN
  input  logic                 scr_bypass,
`endif
  output logic [65:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 hdr_err,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  logic [57:0] state;
  logic [63:0] scr;
  logic [63:0] nxt_payload;
  logic        adv_state;
  logic        accept;
  logic        bad_hdr;

  // Bit i sees E[i] (58 bits back) and E[i+19] (39 bits back); from bit 39 on
  // the 39-back tap lands inside this block, so the loop runs serially by index.
  function automatic logic [63:0] scramble(input logic [63:0] d, input logic [57:0] st);
    logic [121:0] e;
    e = {64'h0, st};
    for (int i = 0; i < 64; i++)
      e[58+i] = d[i] ^ e[i+19] ^ e[i];
    return e[121:58];
  endfunction

  assign scr      = scramble(in_data, state);
  assign in_ready = !reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign bad_hdr  = (in_header == 2'b00) || (in_header == 2'b11);

`ifdef TX6466_SCR_BYPASS_EN
  // A bypassed block is invisible to the scrambler history.
  assign nxt_payload = scr_bypass ? in_data : scr;
  assign adv_state   = !scr_bypass;
`else
  assign nxt_payload = scr;
  assign adv_state   = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED;
      out_valid   <= 1'b0;
      out_data    <= '0;
      hdr_err     <= 1'b0;
      hdr_err_cnt <= '0;
    end else begin
      hdr_err <= 1'b0;
      if (accept) begin
        out_data  <= {in_header, nxt_payload};
        out_valid <= 1'b1;
        if (adv_state)
          state <= scr[63:6];
        if (bad_hdr) begin
          hdr_err <= 1'b1;
          if (hdr_err_cnt != '1)
            hdr_err_cnt <= hdr_err_cnt + CNT_ONE;
        end
      end else begin
        out_valid <= out_valid && !out_ready;
      end
    end
  end

endmodule
